seq_det_sched: RTL

- Round-robin scheduler that shares one serial Mealy sequence detector between two parallel-word requesters.
- Accepts a W-bit word from the granted channel, clears the detector, and shifts the word out MSB-first, one bit per clock.
- Counts the cycles in which the detector flags a hit during the frame, then reports the count with the channel ID.
- Sits between the parallel producers and the serial detector. ser_bit drives the detector input; the detector's combinational output returns on det_hit.

---
 rtl/seq_det_sched_if.sv | 31 +++
 rtl/seq_det_sched.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seq_det_sched_if.sv
// Bundle between the two parallel requesters, the scheduler and the serial detector.
// The scheduler uses the slave view; the environment driving requests and the detector uses the master view.
interface seq_det_sched_if #(
    parameter int W    = 8,
    parameter int CNTW = 4
);
    logic            req0;
    logic [W-1:0]    data0;
    logic            req1;
    logic [W-1:0]    data1;
    logic            gnt0;
    logic            gnt1;
    logic            det_clr;
    logic            ser_bit;
    logic            ser_valid;
    logic            det_hit;
    logic            busy;
    logic            done;
    logic            done_ch;
    logic [CNTW-1:0] hit_cnt;

    modport slave (
        input  req0, data0, req1, data1, det_hit,
        output gnt0, gnt1, det_clr, ser_bit, ser_valid, busy, done, done_ch, hit_cnt
    );

    modport master (
        output req0, data0, req1, data1, det_hit,
        input  gnt0, gnt1, det_clr, ser_bit, ser_valid, busy, done, done_ch, hit_cnt
    );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin scheduler that serialises one of two parallel words MSB-first into a shared
// sequence detector and reports the number of detector hits seen during the frame.
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens on the accepting edge
// LOAD  | word captured, grant pulse to the winner, detector history cleared
// SHIFT | W cycles, one frame bit per cycle, hits counted at each edge
// DONE  | done pulse with channel id; hit_cnt/done_ch then hold until next LOAD
module seq_det_sched #(
    parameter int W    = 8,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            clr,
    seq_det_sched_if.slave  bus
);
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    sreg, sreg_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic            cur_ch, cur_ch_nx;
    logic            last_ch, last_ch_nx;
    logic            winner;

    logic            gnt0_q, gnt1_q, det_clr_q, ser_bit_q, ser_valid_q;
    logic            busy_q, done_q, done_ch_q;
    logic [CNTW-1:0] hit_cnt_q;

    logic            gnt0_nx, gnt1_nx, det_clr_nx, ser_bit_nx, ser_valid_nx;
    logic            busy_nx, done_nx, done_ch_nx;
    logic [CNTW-1:0] hit_cnt_nx;

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            sreg        <= '0;
            idx         <= '0;
            cur_ch      <= 1'b0;
            last_ch     <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            det_clr_q   <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_ch_q   <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            state       <= state_nx;
            sreg        <= sreg_nx;
            idx         <= idx_nx;
            cur_ch      <= cur_ch_nx;
            last_ch     <= last_ch_nx;
            gnt0_q      <= gnt0_nx;
            gnt1_q      <= gnt1_nx;
            det_clr_q   <= det_clr_nx;
            ser_bit_q   <= ser_bit_nx;
            ser_valid_q <= ser_valid_nx;
            busy_q      <= busy_nx;
            done_q      <= done_nx;
            done_ch_q   <= done_ch_nx;
            hit_cnt_q   <= hit_cnt_nx;
        end
    end

    // On contention the channel that was not served last wins.
    assign winner = (bus.req0 && bus.req1) ? ~last_ch : bus.req1;

    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        idx_nx     = idx;
        cur_ch_nx  = cur_ch;
        last_ch_nx = last_ch;
        hit_cnt_nx = hit_cnt_q;
        done_ch_nx = done_ch_q;

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nx   = LOAD;
                    sreg_nx    = winner ? bus.data1 : bus.data0;
                    cur_ch_nx  = winner;
                    last_ch_nx = winner;
                    hit_cnt_nx = '0;
                    idx_nx     = '0;
                end
            end
            LOAD: state_nx = SHIFT;
            SHIFT: begin
                if (bus.det_hit) hit_cnt_nx = hit_cnt_q + 1'b1;
                sreg_nx = sreg << 1;
                idx_nx  = idx + 1'b1;
                if (idx == IW'(W - 1)) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        gnt0_nx      = (state_nx == LOAD) && !cur_ch_nx;
        gnt1_nx      = (state_nx == LOAD) && cur_ch_nx;
        det_clr_nx   = (state_nx == LOAD);
        ser_valid_nx = (state_nx == SHIFT);
        ser_bit_nx   = (state_nx == SHIFT) && sreg_nx[W-1];
        busy_nx      = (state_nx != IDLE);
        done_nx      = (state_nx == DONE);
        if (state_nx == DONE) done_ch_nx = cur_ch_nx;
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.det_clr   = det_clr_q;
    assign bus.ser_bit   = ser_bit_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_ch   = done_ch_q;
    assign bus.hit_cnt   = hit_cnt_q;
endmodule
